ifu_pc_gen: RTL and testbench

- Instruction-fetch program-counter generator for the single-issue RV32 core.
- Holds the architectural PC and updates it once per clock.
- Next PC is sequential (PC + 4) by default. It is PC-relative (PC + imm) on a jump, or on a taken branch (branch asserted and ALU zero flag set).
- Sits at the front of the pipeline. It feeds pc_o to instruction memory and downstream stages; imm and control come from decode/execute.

---
 rtl/ifu_pc_gen.sv | 42 ++++
 tb/tb_ifu_pc_gen.sv | 127 ++++++++++++
 2 files changed

// File: rtl/ifu_pc_gen.sv
// Instruction-fetch PC generator: holds the architectural PC and advances it
// every clock, either sequentially by PC_STEP or PC-relative by imm_i when a
// jump or taken branch is signalled.
module ifu_pc_gen #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic            jump_i,
    input  logic            branch_i,
    input  logic            zero_i,
    output logic [XLEN-1:0] pc_o
);

    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    logic            w_taken;
    logic [XLEN-1:0] w_offset;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] r_pc;

    // A single adder serves both paths. The offset is muxed ahead of it, so
    // an unknown imm_i cannot reach the sequential path.
    assign w_taken   = jump_i | (branch_i & zero_i);
    assign w_offset  = w_taken ? imm_i : STEP;
    assign w_pc_next = r_pc + w_offset;

    // PC register: async reset to RESET_PC, otherwise load the next PC every edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign pc_o = r_pc;

endmodule

// File: tb/tb_ifu_pc_gen.sv
// Directed bench for ifu_pc_gen: hand-computed PC sequence covering reset,
// sequential fetch, jumps, taken/not-taken branches, wrap and mid-run reset.
module tb_ifu_pc_gen;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] imm_i;
    logic        jump_i;
    logic        branch_i;
    logic        zero_i;
    logic [31:0] pc_o;

    int n_vec;
    int n_err;

    ifu_pc_gen #(
        .XLEN    (32),
        .RESET_PC(32'h0000_0000),
        .PC_STEP (4)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .imm_i   (imm_i),
        .jump_i  (jump_i),
        .branch_i(branch_i),
        .zero_i  (zero_i),
        .pc_o    (pc_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: pc_o=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic j, input logic b, input logic z, input logic [31:0] imm);
        jump_i   = j;
        branch_i = b;
        zero_i   = z;
        imm_i    = imm;
    endtask

    // advance one rising edge and settle 1ns past it
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_i = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);

        // reset asserted between edges takes effect at once
        #1 rst_i = 1'b1;
        #1 chk("rst_async", pc_o, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_hold", pc_o, 32'h0);
        end

        // sequential fetch, imm garbage must not matter
        rst_i = 1'b0;
        drive(1'b0, 1'b0, 1'b0, $urandom);
        #1 chk("rel_pc0", pc_o, 32'h0);
        for (int i = 1; i <= 5; i++) begin
            imm_i = $urandom;
            step();
            chk("seq", pc_o, 32'(i * 4));
        end

        // jump at 0x14; no combinational path to pc_o
        drive(1'b1, 1'b0, 1'b0, 32'h8);
        #1 chk("no_comb", pc_o, 32'h14);
        step(); chk("jump", pc_o, 32'h1C);
        drive(1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        step(); chk("jump_after", pc_o, 32'h20);

        // negative offset
        drive(1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8);
        step(); chk("neg_jump", pc_o, 32'h18);

        // reach 0x40, then taken branch with halfword offset
        drive(1'b1, 1'b0, 1'b0, 32'h28);
        step(); chk("jump_to40", pc_o, 32'h40);
        drive(1'b0, 1'b1, 1'b1, 32'hA);
        step(); chk("br_taken", pc_o, 32'h4A);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step(); chk("br_after", pc_o, 32'h4E);

        // not-taken branch variants
        drive(1'b0, 1'b1, 1'b0, 32'h100);
        step(); chk("br_nt_z0", pc_o, 32'h52);
        drive(1'b0, 1'b0, 1'b1, 32'h100);
        step(); chk("br_nt_b0", pc_o, 32'h56);

        // jump together with branch: same adder
        drive(1'b1, 1'b1, 1'b1, 32'h10);
        step(); chk("jump_br", pc_o, 32'h66);
        drive(1'b1, 1'b1, 1'b0, 32'h2);
        step(); chk("jump_br_z0", pc_o, 32'h68);

        // wrap modulo 2^32
        drive(1'b1, 1'b0, 1'b0, 32'hFFFF_FF94);
        step(); chk("to_top", pc_o, 32'hFFFF_FFFC);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step(); chk("wrap", pc_o, 32'h0);
        step(); chk("wrap_next", pc_o, 32'h4);

        // mid-run reset between edges
        #2 rst_i = 1'b1;
        #1 chk("rst_mid", pc_o, 32'h0);
        step(); chk("rst_mid_hold", pc_o, 32'h0);
        rst_i = 1'b0;
        step(); chk("rst_mid_rel", pc_o, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
